// File: rtl/ysyx_201979054_axi_mem_responder.sv
// ysyx_201979054_axi_mem_responder
//   AXI4 memory-side responder for data-cache line fills (AR/R) and
//   write-backs (AW/W/B). One transaction in flight, INCR bursts only, one
//   DATA_W beat per transfer, backed by an internal word RAM.
//   Optional feature macro: MEM_READ_WAIT_EN inserts READ_WAIT idle cycles
//   between the AR handshake and the first R beat.
module ysyx_201979054_axi_mem_responder #(
    parameter int ADDR_W    = 32,
    parameter int DATA_W    = 32,
    parameter int DEPTH     = 1024,
    parameter int READ_WAIT = 4
) (
    input  logic                  clk,
    input  logic                  arst,
    input  logic [ADDR_W-1:0]     i_ar_addr,
    input  logic [7:0]            i_ar_len,
    input  logic                  i_ar_valid,
    output logic                  o_ar_ready,
    output logic [DATA_W-1:0]     o_r_data,
    output logic [1:0]            o_r_resp,
    output logic                  o_r_last,
    output logic                  o_r_valid,
    input  logic                  i_r_ready,
    input  logic [ADDR_W-1:0]     i_aw_addr,
    input  logic [7:0]            i_aw_len,
    input  logic                  i_aw_valid,
    output logic                  o_aw_ready,
    input  logic [DATA_W-1:0]     i_w_data,
    input  logic [DATA_W/8-1:0]   i_w_strb,
    input  logic                  i_w_last,
    input  logic                  i_w_valid,
    output logic                  o_w_ready,
    output logic [1:0]            o_b_resp,
    output logic                  o_b_valid,
    input  logic                  i_b_ready
);

    localparam int STRB_W = DATA_W / 8;
    localparam int OFF_W  = (STRB_W > 1) ? $clog2(STRB_W) : 0;
    localparam int IDX_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int WAIT_W = (READ_WAIT > 1) ? $clog2(READ_WAIT) : 1;
    localparam logic [ADDR_W-1:0] STRIDE = ADDR_W'(STRB_W);
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

`ifdef MEM_READ_WAIT_EN
    localparam logic WAIT_EN = (READ_WAIT != 0);
`else
    localparam logic WAIT_EN = 1'b0;
`endif

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        R_WAIT  = 3'd1,
        R_BURST = 3'd2,
        W_DATA  = 3'd3,
        W_RESP  = 3'd4
    } state_t;

    // A beat is addressable when its word index lies below DEPTH.
    function automatic logic in_range(input logic [ADDR_W-1:0] a);
        return (a >> OFF_W) < ADDR_W'(DEPTH);
    endfunction

    function automatic logic [IDX_W-1:0] word_idx(input logic [ADDR_W-1:0] a);
        return a[OFF_W +: IDX_W];
    endfunction

    logic [DATA_W-1:0] mem [DEPTH];

    state_t              state_r, state_nxt;
    logic [ADDR_W-1:0]   addr_r, addr_nxt;
    logic [7:0]          len_r, len_nxt;
    logic [7:0]          cnt_r, cnt_nxt;
    logic                err_r, err_nxt;
    logic [WAIT_W-1:0]   wait_r, wait_nxt;
    logic                idle_r, idle_nxt;
    logic [DATA_W-1:0]   r_data_r, r_data_nxt;
    logic [1:0]          r_resp_r, r_resp_nxt;
    logic                r_last_r, r_last_nxt;
    logic                r_valid_r, r_valid_nxt;
    logic                w_ready_r, w_ready_nxt;
    logic [1:0]          b_resp_r, b_resp_nxt;
    logic                b_valid_r, b_valid_nxt;

    logic                load_s;
    logic [ADDR_W-1:0]   load_addr_s;
    logic                load_last_s;
    logic                mem_we_s;
    logic [IDX_W-1:0]    mem_idx_s;
    logic                beat_last_s;
    logic                beat_err_s;

    assign o_aw_ready = idle_r;
    assign o_ar_ready = idle_r & ~i_aw_valid;
    assign o_r_data   = r_data_r;
    assign o_r_resp   = r_resp_r;
    assign o_r_last   = r_last_r;
    assign o_r_valid  = r_valid_r;
    assign o_w_ready  = w_ready_r;
    assign o_b_resp   = b_resp_r;
    assign o_b_valid  = b_valid_r;

    assign beat_last_s = (cnt_r == len_r);
    assign beat_err_s  = ~in_range(addr_r) | (i_w_last != beat_last_s);

    // Next-state and next-output computation for the transaction FSM.
    always_comb begin
        state_nxt   = state_r;
        addr_nxt    = addr_r;
        len_nxt     = len_r;
        cnt_nxt     = cnt_r;
        err_nxt     = err_r;
        wait_nxt    = wait_r;
        idle_nxt    = idle_r;
        r_data_nxt  = r_data_r;
        r_resp_nxt  = r_resp_r;
        r_last_nxt  = r_last_r;
        r_valid_nxt = r_valid_r;
        w_ready_nxt = w_ready_r;
        b_resp_nxt  = b_resp_r;
        b_valid_nxt = b_valid_r;
        load_s      = 1'b0;
        load_addr_s = addr_r;
        load_last_s = 1'b0;
        mem_we_s    = 1'b0;
        mem_idx_s   = word_idx(addr_r);

        case (state_r)
            IDLE: begin
                idle_nxt = 1'b1;
                if (idle_r && i_aw_valid) begin
                    addr_nxt    = i_aw_addr;
                    len_nxt     = i_aw_len;
                    cnt_nxt     = 8'd0;
                    err_nxt     = 1'b0;
                    idle_nxt    = 1'b0;
                    w_ready_nxt = 1'b1;
                    state_nxt   = W_DATA;
                end else if (idle_r && i_ar_valid) begin
                    addr_nxt = i_ar_addr;
                    len_nxt  = i_ar_len;
                    cnt_nxt  = 8'd0;
                    idle_nxt = 1'b0;
                    if (WAIT_EN) begin
                        wait_nxt  = WAIT_W'(READ_WAIT - 1);
                        state_nxt = R_WAIT;
                    end else begin
                        load_s      = 1'b1;
                        load_addr_s = i_ar_addr;
                        load_last_s = (i_ar_len == 8'd0);
                        r_valid_nxt = 1'b1;
                        state_nxt   = R_BURST;
                    end
                end else begin
                    state_nxt = IDLE;
                end
            end
            R_WAIT: begin
                if (wait_r == WAIT_W'(0)) begin
                    load_s      = 1'b1;
                    load_addr_s = addr_r;
                    load_last_s = (len_r == 8'd0);
                    r_valid_nxt = 1'b1;
                    state_nxt   = R_BURST;
                end else begin
                    wait_nxt = wait_r - WAIT_W'(1);
                end
            end
            R_BURST: begin
                if (r_valid_r && i_r_ready) begin
                    if (beat_last_s) begin
                        r_valid_nxt = 1'b0;
                        r_last_nxt  = 1'b0;
                        state_nxt   = IDLE;
                    end else begin
                        addr_nxt    = addr_r + STRIDE;
                        cnt_nxt     = cnt_r + 8'd1;
                        load_s      = 1'b1;
                        load_addr_s = addr_r + STRIDE;
                        load_last_s = ((cnt_r + 8'd1) == len_r);
                    end
                end else begin
                    state_nxt = R_BURST;
                end
            end
            W_DATA: begin
                if (i_w_valid && w_ready_r) begin
                    mem_we_s = in_range(addr_r);
                    err_nxt  = err_r | beat_err_s;
                    if (beat_last_s) begin
                        w_ready_nxt = 1'b0;
                        b_valid_nxt = 1'b1;
                        b_resp_nxt  = (err_r | beat_err_s) ? RESP_SLVERR : RESP_OKAY;
                        state_nxt   = W_RESP;
                    end else begin
                        addr_nxt = addr_r + STRIDE;
                        cnt_nxt  = cnt_r + 8'd1;
                    end
                end else begin
                    state_nxt = W_DATA;
                end
            end
            W_RESP: begin
                if (i_b_ready) begin
                    b_valid_nxt = 1'b0;
                    b_resp_nxt  = RESP_OKAY;
                    state_nxt   = IDLE;
                end else begin
                    state_nxt = W_RESP;
                end
            end
            default: begin
                state_nxt   = IDLE;
                r_valid_nxt = 1'b0;
                w_ready_nxt = 1'b0;
                b_valid_nxt = 1'b0;
                idle_nxt    = 1'b0;
            end
        endcase

        // Fetch the beat about to be presented; unmapped beats read as zero.
        if (load_s) begin
            if (in_range(load_addr_s)) begin
                r_data_nxt = mem[word_idx(load_addr_s)];
                r_resp_nxt = RESP_OKAY;
            end else begin
                r_data_nxt = '0;
                r_resp_nxt = RESP_SLVERR;
            end
            r_last_nxt = load_last_s;
        end else begin
            r_data_nxt = r_data_nxt;
        end
    end

    // State and registered AXI outputs; reset aborts any burst in progress.
    always_ff @(posedge clk) begin
        if (arst) begin
            state_r   <= IDLE;
            addr_r    <= '0;
            len_r     <= 8'd0;
            cnt_r     <= 8'd0;
            err_r     <= 1'b0;
            wait_r    <= '0;
            idle_r    <= 1'b0;
            r_data_r  <= '0;
            r_resp_r  <= RESP_OKAY;
            r_last_r  <= 1'b0;
            r_valid_r <= 1'b0;
            w_ready_r <= 1'b0;
            b_resp_r  <= RESP_OKAY;
            b_valid_r <= 1'b0;
        end else begin
            state_r   <= state_nxt;
            addr_r    <= addr_nxt;
            len_r     <= len_nxt;
            cnt_r     <= cnt_nxt;
            err_r     <= err_nxt;
            wait_r    <= wait_nxt;
            idle_r    <= idle_nxt;
            r_data_r  <= r_data_nxt;
            r_resp_r  <= r_resp_nxt;
            r_last_r  <= r_last_nxt;
            r_valid_r <= r_valid_nxt;
            w_ready_r <= w_ready_nxt;
            b_resp_r  <= b_resp_nxt;
            b_valid_r <= b_valid_nxt;
        end
    end

    // Byte-masked RAM write; contents are deliberately not reset.
    always_ff @(posedge clk) begin
        for (int b = 0; b < STRB_W; b++) begin
            if (!arst && mem_we_s && i_w_strb[b]) begin
                mem[mem_idx_s][b*8 +: 8] <= i_w_data[b*8 +: 8];
            end
        end
    end

endmodule
